keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of row inputs (>=2).
REQ-002 Parameter COLS, default 4, number of column drive outputs (>=2).
REQ-003 Parameter SCAN_DIV, default 16, clock cycles each column stays active while scanning (>=1).
REQ-004 Parameter DEBOUNCE_CYC, default 4, consecutive stable cycles required to accept a press or a release (>=1).
REQ-005 Parameter REPEAT_DELAY, default 1000, cycles held before the first auto-repeat; used only under KEYPAD_REPEAT_EN.
REQ-006 Parameter REPEAT_PERIOD, default 250, cycles between later auto-repeats; used only under KEYPAD_REPEAT_EN.
REQ-007 clk  input  1  single clock; all state is posedge clk.
REQ-008 nRst  input  1  asynchronous, active-low reset.
REQ-009 read_row  input  ROWS  raw asynchronous row sense lines; high means pressed.
REQ-010 scan_col  output  COLS  one-hot column drive.
REQ-011 key_valid  output  1  event pending; held until accepted.
REQ-012 key_ready  input  1  consumer accepts the event when key_valid && key_ready.
REQ-013 key_row  output  RW=max(1,$clog2(ROWS))  row index of the event.
REQ-014 key_col  output  CW=max(1,$clog2(COLS))  column index of the event.
REQ-015 key_press  output  1  1 = press or repeat, 0 = release.
REQ-016 key_ovf  output  1  one-cycle pulse when an event is dropped.

Function
REQ-017 read_row shall pass through a 2-flop synchronizer (sync_row); all decisions use sync_row only.
REQ-018 The FSM shall have exactly four states: SCAN, PRESS_DB, HELD and REL_DB.
REQ-019 In SCAN, a dwell counter shall count 0..SCAN_DIV-1; at terminal count scan_col rotates right (bit COLS-1 toward bit 0, with bit 0 wrapping to bit COLS-1).
REQ-020 In SCAN, if sync_row!=0 and scan_col!=0 at dwell terminal count, the block shall latch sync_row and the column index, freeze scan_col, clear the debounce counter and enter PRESS_DB.
REQ-021 In PRESS_DB, each cycle with sync_row==latched row shall increment the counter; any mismatch shall return to SCAN with dwell cleared, resuming from the next column.
REQ-022 When the PRESS_DB count reaches DEBOUNCE_CYC: if the latched row is one-hot, the block shall emit a press event (key_row = set-bit index) and enter HELD; if more than one bit is set (ghost), it shall enter HELD with no event and suppress the later release event.
REQ-023 In HELD, sync_row==0 shall enter REL_DB with the counter cleared.
REQ-024 In REL_DB, DEBOUNCE_CYC consecutive cycles of sync_row==0 shall emit a release event with the same row and column and then enter SCAN; a nonzero sync_row shall return to HELD.
REQ-025 The event output shall be a 1-entry register: a new event loads when key_valid==0, or when key_valid && key_ready in the same cycle.
REQ-026 A new event arriving while key_valid && !key_ready shall be dropped, the held event kept and key_ovf pulsed for one cycle.
REQ-027 key_row, key_col and key_press shall stay stable while key_valid is high.

Reset
REQ-028 On nRst low: state=SCAN, scan_col=0, counters=0, synchronizer=0, key_valid=0, key_row=0, key_col=0, key_press=0, key_ovf=0.
REQ-029 In the first cycle after reset release, scan_col shall become 1<<(COLS-1).
REQ-030 Reset asserted mid-debounce or with an event pending shall discard all state with no event emitted.

Configuration
REQ-031 With macro KEYPAD_REPEAT_EN defined, the HELD state shall emit a press event (key_press=1, same row and column) REPEAT_DELAY cycles after entry, then every REPEAT_PERIOD cycles, and never for a ghost press.
REQ-032 Without KEYPAD_REPEAT_EN, the repeat counter and its logic shall be absent and HELD shall emit no events.

Structure
REQ-033 Package keypad_pkg shall hold the state enum type (kp_state_t) and the row-index encoder function.
REQ-034 Sub-module keypad_sync (parametrised width, 2-flop synchronizer with async active-low reset) shall implement REQ-017.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_CYC=3 unless stated)
REQ-035 Hold read_row=4'b0100 while scan_col=4'b0010 -> one event: key_row=2, key_col=1, key_press=1. Release -> one event with key_press=0 and the same indices.
REQ-036 Press with a 2-cycle bounce (row 0100 -> 0000 -> 0100) during PRESS_DB -> no event; scanning resumes; a later stable press produces exactly one event.
REQ-037 read_row=4'b0101 -> no press event and no release event; scanning resumes after release.
REQ-038 key_ready=0 with a press then a release -> first event held, key_ovf pulses once. Raising key_ready in the cycle the next event arrives -> no drop.
REQ-039 nRst pulsed low during PRESS_DB -> all outputs are 0, scan_col=0001000... wrapping as per REQ-029 (4'b1000 the first cycle after release), and no event.
REQ-040 With KEYPAD_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=8, key held for 40 cycles after HELD entry -> initial press event plus repeats at +20, +28 and +36 cycles.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner.
// Holds the scanner state enum and the bit-index encoders used for both
// row and column indices (vectors up to 32 bits wide).
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kp_state_t;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic int unsigned row_index(input logic [31:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

   // True when exactly one bit is set.
   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event handshake bundle: the scanner drives an event (row, column,
// press/release) with valid/ready flow control plus a drop indicator.
interface keypad_scanner_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4
);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   logic          key_valid;
   logic          key_ready;
   logic [RW-1:0] key_row;
   logic [CW-1:0] key_col;
   logic          key_press;
   logic          key_ovf;

   modport master (
      output key_valid, key_row, key_col, key_press, key_ovf,
      input  key_ready
   );

   modport slave (
      input  key_valid, key_row, key_col, key_press, key_ovf,
      output key_ready
   );
endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the raw, asynchronous row sense lines.
module keypad_sync #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         nRst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two back-to-back flops give metastability time before any decision.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one column at a time, debounces presses and
// releases on the synchronized row lines, rejects multi-row (ghost) presses
// and emits key events through a 1-entry valid/ready output register.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS          = 4,
   parameter int COLS          = 4,
   parameter int SCAN_DIV      = 16,
   parameter int DEBOUNCE_CYC  = 4,
   parameter int REPEAT_DELAY  = 1000,
   parameter int REPEAT_PERIOD = 250
) (
   input  logic              clk,
   input  logic              nRst,
   input  logic [ROWS-1:0]   read_row,
   output logic [COLS-1:0]   scan_col,
   keypad_scanner_if.master  kif
);
   localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DVW-1:0] DWELL_LAST = DVW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYC - 1);

   // Encoders take 32-bit vectors, so the matrix is limited to 32x32.
   if (ROWS < 2 || COLS < 2 || ROWS > 32 || COLS > 32 || SCAN_DIV < 1 ||
       DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
      $error("keypad_scanner: illegal parameter value");
   end

   logic [ROWS-1:0] sync_row;

   keypad_sync #(.W(ROWS)) u_sync (
      .clk  (clk),
      .nRst (nRst),
      .d_i  (read_row),
      .q_o  (sync_row)
   );

   kp_state_t       state_q,   state_d;
   logic [COLS-1:0] scan_col_q, scan_col_d;
   logic [DVW-1:0]  dwell_q,   dwell_d;
   logic [DBW-1:0]  db_q,      db_d;
   logic [ROWS-1:0] row_lat_q, row_lat_d;
   logic [CW-1:0]   col_lat_q, col_lat_d;
   logic            ghost_q,   ghost_d;

   logic            key_valid_q, key_valid_d;
   logic [RW-1:0]   key_row_q,   key_row_d;
   logic [CW-1:0]   key_col_q,   key_col_d;
   logic            key_press_q, key_press_d;
   logic            key_ovf_q,   key_ovf_d;

   logic            ev_new;
   logic            ev_press;
   logic [RW-1:0]   ev_row;
   logic [CW-1:0]   col_idx;
   logic [COLS-1:0] rot_col;
   logic            row_onehot;

   assign rot_col    = {scan_col_q[0], scan_col_q[COLS-1:1]};
   assign col_idx    = CW'(row_index(32'(scan_col_q)));
   assign ev_row     = RW'(row_index(32'(row_lat_q)));
   assign row_onehot = is_onehot(32'(row_lat_q));

`ifdef KEYPAD_REPEAT_EN
   logic [31:0] rep_q, rep_d;
   logic        rep_arm_q, rep_arm_d;
   logic [31:0] rep_target;
   logic [31:0] rep_inc;

   assign rep_target = rep_arm_q ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY);
   assign rep_inc    = rep_q + 32'd1;

   // Repeat counter: cycles since HELD entry, then since the last repeat.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rep_q     <= '0;
         rep_arm_q <= 1'b0;
      end else begin
         rep_q     <= rep_d;
         rep_arm_q <= rep_arm_d;
      end
   end
`endif

   // Scanner and event register state.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= SCAN;
         scan_col_q  <= '0;
         dwell_q     <= '0;
         db_q        <= '0;
         row_lat_q   <= '0;
         col_lat_q   <= '0;
         ghost_q     <= 1'b0;
         key_valid_q <= 1'b0;
         key_row_q   <= '0;
         key_col_q   <= '0;
         key_press_q <= 1'b0;
         key_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         scan_col_q  <= scan_col_d;
         dwell_q     <= dwell_d;
         db_q        <= db_d;
         row_lat_q   <= row_lat_d;
         col_lat_q   <= col_lat_d;
         ghost_q     <= ghost_d;
         key_valid_q <= key_valid_d;
         key_row_q   <= key_row_d;
         key_col_q   <= key_col_d;
         key_press_q <= key_press_d;
         key_ovf_q   <= key_ovf_d;
      end
   end

   // Next-state logic: column scan, press/release debounce, event requests.
   always_comb begin
      state_d    = state_q;
      scan_col_d = scan_col_q;
      dwell_d    = dwell_q;
      db_d       = db_q;
      row_lat_d  = row_lat_q;
      col_lat_d  = col_lat_q;
      ghost_d    = ghost_q;
      ev_new     = 1'b0;
      ev_press   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d      = rep_q;
      rep_arm_d  = rep_arm_q;
`endif
      case (state_q)
         SCAN: begin
            if (scan_col_q == '0) begin
               // Leaving reset: start driving the top column.
               scan_col_d = {1'b1, {(COLS-1){1'b0}}};
               dwell_d    = '0;
            end else if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
               if (sync_row != '0) begin
                  // Freeze on this column and debounce the row pattern.
                  row_lat_d = sync_row;
                  col_lat_d = col_idx;
                  db_d      = '0;
                  state_d   = PRESS_DB;
               end else begin
                  scan_col_d = rot_col;
               end
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end

         PRESS_DB: begin
            if (sync_row == row_lat_q) begin
               if (db_q == DB_LAST) begin
                  // Stable long enough; multi-row patterns are ghosts and stay silent.
                  db_d     = '0;
                  state_d  = HELD;
                  ghost_d  = !row_onehot;
                  ev_new   = row_onehot;
                  ev_press = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                  rep_d     = '0;
                  rep_arm_d = 1'b0;
`endif
               end else begin
                  db_d = db_q + 1'b1;
               end
            end else begin
               // Bounce: drop the candidate and continue with the next column.
               state_d    = SCAN;
               dwell_d    = '0;
               scan_col_d = rot_col;
            end
         end

         HELD: begin
            if (sync_row == '0) begin
               state_d = REL_DB;
               db_d    = '0;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (!ghost_q) begin
               if (rep_inc == rep_target) begin
                  ev_new    = 1'b1;
                  ev_press  = 1'b1;
                  rep_d     = '0;
                  rep_arm_d = 1'b1;
               end else begin
                  rep_d = rep_inc;
               end
            end
`endif
         end

         REL_DB: begin
            if (sync_row != '0) begin
               state_d = HELD;
            end else if (db_q == DB_LAST) begin
               state_d    = SCAN;
               ev_new     = !ghost_q;
               ev_press   = 1'b0;
               dwell_d    = '0;
               scan_col_d = rot_col;
            end else begin
               db_d = db_q + 1'b1;
            end
         end

         default: state_d = SCAN;
      endcase
   end

   // One-entry event register: load when empty or being drained, else drop and flag.
   always_comb begin
      key_valid_d = key_valid_q;
      key_row_d   = key_row_q;
      key_col_d   = key_col_q;
      key_press_d = key_press_q;
      key_ovf_d   = 1'b0;
      if (ev_new && (!key_valid_q || kif.key_ready)) begin
         key_valid_d = 1'b1;
         key_row_d   = ev_row;
         key_col_d   = col_lat_q;
         key_press_d = ev_press;
      end else begin
         if (key_valid_q && kif.key_ready) key_valid_d = 1'b0;
         if (ev_new) key_ovf_d = 1'b1;
      end
   end

   assign scan_col      = scan_col_q;
   assign kif.key_valid = key_valid_q;
   assign kif.key_row   = key_row_q;
   assign kif.key_col   = key_col_q;
   assign kif.key_press = key_press_q;
   assign kif.key_ovf   = key_ovf_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_CYC=3).
// Accepted events are logged by a monitor; checks compare against hand-derived values.
module tb_keypad_scanner;
   logic       clk = 1'b0;
   logic       nRst = 1'b0;
   logic [3:0] read_row = 4'b0000;
   logic [3:0] scan_col;

   int n_chk = 0;
   int n_bad = 0;

   keypad_scanner_if #(.ROWS(4), .COLS(4)) kif();

   keypad_scanner #(
      .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYC(3),
      .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
   ) dut (
      .clk      (clk),
      .nRst     (nRst),
      .read_row (read_row),
      .scan_col (scan_col),
      .kif      (kif)
   );

   always #5 clk = ~clk;

   // Event log of accepted handshakes and overflow pulse count.
   logic [1:0] lg_row   [64];
   logic [1:0] lg_col   [64];
   logic       lg_press [64];
   int         lg_cyc   [64];
   int         ev_n  = 0;
   int         ovf_n = 0;
   int         cyc_n = 0;

   always @(posedge clk) begin
      cyc_n <= cyc_n + 1;
      if (nRst && kif.key_valid && kif.key_ready && ev_n < 64) begin
         lg_row[ev_n]   <= kif.key_row;
         lg_col[ev_n]   <= kif.key_col;
         lg_press[ev_n] <= kif.key_press;
         lg_cyc[ev_n]   <= cyc_n;
         ev_n           <= ev_n + 1;
      end
      if (nRst && kif.key_ovf) ovf_n <= ovf_n + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the negedge right after scan_col switches to tgt.
   task automatic wait_scan(input logic [3:0] tgt);
      int n;
      n = 0;
      while (scan_col == tgt && n < 200) begin cyc(1); n++; end
      while (scan_col != tgt && n < 200) begin cyc(1); n++; end
      check("scan_reach", 32'(scan_col), 32'(tgt));
   endtask

   int b;
   int o;

   initial begin
      kif.key_ready = 1'b1;
      cyc(3);
      // Reset state
      check("rst_scan",  32'(scan_col), 32'h0);
      check("rst_valid", 32'(kif.key_valid), 32'h0);
      check("rst_row",   32'(kif.key_row), 32'h0);
      check("rst_col",   32'(kif.key_col), 32'h0);
      check("rst_press", 32'(kif.key_press), 32'h0);
      check("rst_ovf",   32'(kif.key_ovf), 32'h0);
      nRst = 1'b1;
      cyc(1);
      check("first_col", 32'(scan_col), 32'h8);
      cyc(3);
      check("dwell_hold", 32'(scan_col), 32'h8);
      cyc(1);
      check("rotate", 32'(scan_col), 32'h4);

      // Single clean press and release at row 2, column 1
      b = ev_n; o = ovf_n;
      wait_scan(4'b0010);
      read_row = 4'b0100;
      cyc(15);
      check("held_col", 32'(scan_col), 32'h2);
      read_row = 4'b0000;
      cyc(15);
      check("t1_count", 32'(ev_n - b), 32'd2);
      check("t1_row0",  32'(lg_row[b]), 32'd2);
      check("t1_col0",  32'(lg_col[b]), 32'd1);
      check("t1_prs0",  32'(lg_press[b]), 32'd1);
      check("t1_row1",  32'(lg_row[b+1]), 32'd2);
      check("t1_col1",  32'(lg_col[b+1]), 32'd1);
      check("t1_prs1",  32'(lg_press[b+1]), 32'd0);
      check("t1_ovf",   32'(ovf_n - o), 32'd0);

      // Bounce during press debounce: no event, scan resumes at the next column
      b = ev_n;
      wait_scan(4'b0010);
      read_row = 4'b0100;
      cyc(3);
      read_row = 4'b0000;
      cyc(2);
      read_row = 4'b0100;
      cyc(1);
      check("bounce_resume", 32'(scan_col), 32'h1);
      read_row = 4'b0000;
      cyc(12);
      check("bounce_none", 32'(ev_n - b), 32'd0);
      wait_scan(4'b0100);
      read_row = 4'b0010;
      cyc(15);
      read_row = 4'b0000;
      cyc(15);
      check("t2_count", 32'(ev_n - b), 32'd2);
      check("t2_row0",  32'(lg_row[b]), 32'd1);
      check("t2_col0",  32'(lg_col[b]), 32'd2);
      check("t2_prs0",  32'(lg_press[b]), 32'd1);

      // Ghost (two rows): neither press nor release reported
      b = ev_n;
      wait_scan(4'b0010);
      read_row = 4'b0101;
      cyc(15);
      read_row = 4'b0000;
      cyc(15);
      check("ghost_none", 32'(ev_n - b), 32'd0);
      wait_scan(4'b0001);

      // Consumer stalled: release dropped, held press kept
      b = ev_n; o = ovf_n;
      kif.key_ready = 1'b0;
      wait_scan(4'b0010);
      read_row = 4'b0100;
      cyc(12);
      check("stall_valid", 32'(kif.key_valid), 32'h1);
      check("stall_press", 32'(kif.key_press), 32'h1);
      check("stall_row",   32'(kif.key_row), 32'd2);
      read_row = 4'b0000;
      cyc(15);
      check("ovf_pulse",  32'(ovf_n - o), 32'd1);
      check("kept_valid", 32'(kif.key_valid), 32'h1);
      check("kept_press", 32'(kif.key_press), 32'h1);
      check("kept_col",   32'(kif.key_col), 32'd1);
      kif.key_ready = 1'b1;
      cyc(2);
      check("drain_count", 32'(ev_n - b), 32'd1);
      check("drain_press", 32'(lg_press[b]), 32'd1);
      check("drain_valid", 32'(kif.key_valid), 32'h0);

      // Ready raised in the very cycle the release event arrives
      b = ev_n; o = ovf_n;
      kif.key_ready = 1'b0;
      wait_scan(4'b0010);
      read_row = 4'b0100;
      cyc(12);
      read_row = 4'b0000;
      cyc(5);
      kif.key_ready = 1'b1;
      cyc(1);
      check("swap_valid", 32'(kif.key_valid), 32'h1);
      check("swap_press", 32'(kif.key_press), 32'h0);
      cyc(3);
      check("swap_count", 32'(ev_n - b), 32'd2);
      check("swap_prs0",  32'(lg_press[b]), 32'd1);
      check("swap_prs1",  32'(lg_press[b+1]), 32'd0);
      check("swap_ovf",   32'(ovf_n - o), 32'd0);

      // Reset asserted during press debounce
      b = ev_n;
      wait_scan(4'b0010);
      read_row = 4'b0100;
      cyc(5);
      nRst = 1'b0;
      #1;
      check("mid_rst_scan",  32'(scan_col), 32'h0);
      check("mid_rst_valid", 32'(kif.key_valid), 32'h0);
      check("mid_rst_row",   32'(kif.key_row), 32'h0);
      check("mid_rst_col",   32'(kif.key_col), 32'h0);
      check("mid_rst_press", 32'(kif.key_press), 32'h0);
      check("mid_rst_ovf",   32'(kif.key_ovf), 32'h0);
      read_row = 4'b0000;
      cyc(2);
      nRst = 1'b1;
      cyc(1);
      check("mid_rst_first", 32'(scan_col), 32'h8);
      cyc(20);
      check("mid_rst_noev", 32'(ev_n - b), 32'd0);

`ifdef KEYPAD_REPEAT_EN
      // Auto-repeat: press, then repeats 20, 28 and 36 cycles after HELD entry
      b = ev_n;
      wait_scan(4'b0010);
      read_row = 4'b0100;
      cyc(45);
      read_row = 4'b0000;
      cyc(15);
      check("rep_count", 32'(ev_n - b), 32'd5);
      check("rep_gap0",  32'(lg_cyc[b+1] - lg_cyc[b]), 32'd20);
      check("rep_gap1",  32'(lg_cyc[b+2] - lg_cyc[b+1]), 32'd8);
      check("rep_gap2",  32'(lg_cyc[b+3] - lg_cyc[b+2]), 32'd8);
      check("rep_prs3",  32'(lg_press[b+3]), 32'd1);
      check("rep_row3",  32'(lg_row[b+3]), 32'd2);
      check("rep_rel",   32'(lg_press[b+4]), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
